// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with write bypass, pending scoreboard and bulk-clear engine.
module rf_mp #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter bit ZERO_R0 = 1,
  parameter bit BYPASS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a,
  output logic [NRD-1:0]      pend,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pnd;
  logic [AW-1:0] idx;
  logic last, start, done_nxt;
  assign clr_busy = state == CLEAR;
  assign last = clr_busy && idx == AW'(NREG - 1);
  assign start = state == IDLE && clr_req;
  always_comb begin
    nxt = state == IDLE ? (clr_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    done_nxt = last;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      clr_done <= 1'b0;
    end else begin
      state <= nxt;
      clr_done <= done_nxt;
      idx <= start ? '0 : clr_busy ? idx + 1'b1 : idx;
    end
  // Ascending port order makes the highest-index port win on address collisions.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (clr_busy) begin
      regs[idx] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (we[k] && !(ZERO_R0 && wa[k*AW +: AW] == '0)) regs[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
    end
  // Reserve is applied after write-release so a newly issued producer keeps the bit set.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pnd <= '0;
    end else if (start) begin
      pnd <= '0;
    end else if (!clr_busy) begin
      for (int k = 0; k < NWR; k++)
        if (we[k]) pnd[wa[k*AW +: AW]] <= 1'b0;
      if (rsv_en && !(ZERO_R0 && rsv_a == '0)) pnd[rsv_a] <= 1'b1;
    end
  always_comb begin
    rd = '0;
    pend = '0;
    for (int j = 0; j < NRD; j++) begin
      rd[j*XLEN +: XLEN] = regs[ra[j*AW +: AW]];
      if (BYPASS && !clr_busy)
        for (int k = 0; k < NWR; k++)
          if (we[k] && wa[k*AW +: AW] == ra[j*AW +: AW]) rd[j*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
      if (ZERO_R0 && ra[j*AW +: AW] == '0) rd[j*XLEN +: XLEN] = '0;
      pend[j] = pnd[ra[j*AW +: AW]];
    end
  end
endmodule
